// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready pipeline stage register with a 2-entry skid buffer.
// Main entry drives out_*; skid catches one extra entry so in_ready is a flop.
// Optional perf counters (stall_cnt, bubble_cnt) under ELASTIC_PIPE_REG_PERF_EN.
module elastic_pipe_reg #(
    parameter int unsigned CTRL_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_WIDTH-1:0] in_ctrl,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_WIDTH-1:0] out_ctrl,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef ELASTIC_PIPE_REG_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  bubble_cnt
`endif
);

    logic                  r_m_v;
    logic [CTRL_WIDTH-1:0] r_m_ctrl;
    logic [DATA_WIDTH-1:0] r_m_data;
    logic                  r_s_v;
    logic [CTRL_WIDTH-1:0] r_s_ctrl;
    logic [DATA_WIDTH-1:0] r_s_data;
    logic                  r_in_ready;

    logic                  w_m_v_next;
    logic [CTRL_WIDTH-1:0] w_m_ctrl_next;
    logic [DATA_WIDTH-1:0] w_m_data_next;
    logic                  w_s_v_next;
    logic [CTRL_WIDTH-1:0] w_s_ctrl_next;
    logic [DATA_WIDTH-1:0] w_s_data_next;
    logic                  w_accept;
    logic                  w_drain;

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_m_v & out_ready;

    // Next-state for main/skid entries; flush kills both but a drain still completes downstream.
    always_comb begin
        w_m_v_next    = r_m_v;
        w_m_ctrl_next = r_m_ctrl;
        w_m_data_next = r_m_data;
        w_s_v_next    = r_s_v;
        w_s_ctrl_next = r_s_ctrl;
        w_s_data_next = r_s_data;
        if (flush) begin
            // Data regs deliberately keep their values; only valid/ctrl are cleared.
            w_m_v_next    = 1'b0;
            w_s_v_next    = 1'b0;
            w_m_ctrl_next = '0;
            w_s_ctrl_next = '0;
        end else if (w_drain) begin
            if (r_s_v) begin
                // FULL: skid moves up; in_ready was 0 so nothing new can arrive.
                w_m_v_next    = 1'b1;
                w_m_ctrl_next = r_s_ctrl;
                w_m_data_next = r_s_data;
                w_s_v_next    = 1'b0;
            end else if (w_accept) begin
                w_m_v_next    = 1'b1;
                w_m_ctrl_next = in_ctrl;
                w_m_data_next = in_data;
            end else begin
                w_m_v_next    = 1'b0;
            end
        end else if (w_accept) begin
            if (r_m_v) begin
                // Main is stuck: park the new entry behind it to keep FIFO order.
                w_s_v_next    = 1'b1;
                w_s_ctrl_next = in_ctrl;
                w_s_data_next = in_data;
            end else begin
                w_m_v_next    = 1'b1;
                w_m_ctrl_next = in_ctrl;
                w_m_data_next = in_data;
            end
        end
    end

    // Entry registers and registered in_ready; rst has priority over flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_v      <= 1'b0;
            r_m_ctrl   <= '0;
            r_m_data   <= '0;
            r_s_v      <= 1'b0;
            r_s_ctrl   <= '0;
            r_s_data   <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_m_v      <= w_m_v_next;
            r_m_ctrl   <= w_m_ctrl_next;
            r_m_data   <= w_m_data_next;
            r_s_v      <= w_s_v_next;
            r_s_ctrl   <= w_s_ctrl_next;
            r_s_data   <= w_s_data_next;
            r_in_ready <= ~w_s_v_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_m_v;
    assign out_ctrl  = r_m_v ? r_m_ctrl : '0;
    assign out_data  = r_m_data;

`ifdef ELASTIC_PIPE_REG_PERF_EN
    localparam logic [CNT_WIDTH-1:0] CntOne = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_bubble_cnt;

    // Saturating stall/bubble counters; cleared only by rst, not by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (r_m_v && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CntOne;
            end
            if (!r_m_v && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CntOne;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
